// File: rtl/dice_router_cfg_loader.sv
// Config loader for one CGRA router tile: collects a multi-word frame into a shadow
// register, validates it, and swaps it into the active router controls on commit.
module dice_router_cfg_loader #(
    parameter int unsigned NUM_OUT = 12,
    parameter int unsigned SEL_W   = 4,
    parameter int unsigned MAX_SEL = 9,
    parameter int unsigned WORDS   = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       cfg_valid,
    output logic                       cfg_ready,
    input  logic [31:0]                cfg_data,
    input  logic                       cfg_last,
    input  logic                       commit_en,
    input  logic                       cfg_err_clr,
    output logic [NUM_OUT*SEL_W-1:0]   sel_o,
    output logic [NUM_OUT-1:0]         overload_en_o,
    output logic [NUM_OUT-1:0]         registered_mode_o,
    output logic                       cfg_pending,
    output logic                       cfg_done,
    output logic                       cfg_err
);

    localparam int unsigned FRAME_W  = WORDS * 32;
    localparam int unsigned SEL_BITS = NUM_OUT * SEL_W;
    localparam int unsigned OVL_LSB  = SEL_BITS;
    localparam int unsigned REG_LSB  = SEL_BITS + NUM_OUT;
    localparam int unsigned CNT_W    = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        PEND = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [FRAME_W-1:0]   shadow_q, shadow_d;
    logic [SEL_BITS-1:0]  sel_q, sel_d;
    logic [NUM_OUT-1:0]   ovl_q, ovl_d;
    logic [NUM_OUT-1:0]   regm_q, regm_d;
    logic                 ready_q, ready_d;
    logic                 pending_q, pending_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;

    logic [FRAME_W-1:0]   frame_c;
    logic                 accept_c;
    logic                 last_idx_c;
    logic                 sel_bad_c;
    logic                 frame_err_c;

    // Frame image as it would look with the current word written at the counter index.
    always_comb begin
        frame_c = shadow_q;
        for (int unsigned w = 0; w < WORDS; w++) begin
            if (cnt_q == CNT_W'(w)) begin
                frame_c[w*32 +: 32] = cfg_data;
            end
        end
    end

    always_comb begin
        sel_bad_c = 1'b0;
        for (int unsigned k = 0; k < NUM_OUT; k++) begin
            if (frame_c[SEL_W*k +: SEL_W] > SEL_W'(MAX_SEL)) begin
                sel_bad_c = 1'b1;
            end
        end
    end

    assign accept_c    = cfg_valid & ready_q;
    assign last_idx_c  = (cnt_q == CNT_W'(WORDS - 1));
    // Selects are only judged once the frame is complete.
    assign frame_err_c = (cfg_last != last_idx_c) | (last_idx_c & sel_bad_c);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        sel_d    = sel_q;
        ovl_d    = ovl_q;
        regm_d   = regm_q;
        done_d   = 1'b0;
        err_d    = err_q & ~cfg_err_clr;

        case (state_q)
            IDLE, LOAD: begin
                if (accept_c) begin
                    if (frame_err_c) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        err_d   = 1'b1;
                    end else begin
                        shadow_d = frame_c;
                        if (last_idx_c) begin
                            state_d = PEND;
                            cnt_d   = '0;
                        end else begin
                            state_d = LOAD;
                            cnt_d   = cnt_q + CNT_W'(1);
                        end
                    end
                end
            end
            PEND: begin
                if (commit_en) begin
                    sel_d   = shadow_q[SEL_BITS-1:0];
                    ovl_d   = shadow_q[OVL_LSB +: NUM_OUT];
                    regm_d  = shadow_q[REG_LSB +: NUM_OUT];
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        ready_d   = (state_d != PEND);
        pending_d = (state_d == PEND);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            shadow_q  <= '0;
            sel_q     <= '1;
            ovl_q     <= '0;
            regm_q    <= '0;
            ready_q   <= 1'b1;
            pending_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shadow_q  <= shadow_d;
            sel_q     <= sel_d;
            ovl_q     <= ovl_d;
            regm_q    <= regm_d;
            ready_q   <= ready_d;
            pending_q <= pending_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign cfg_ready         = ready_q;
    assign cfg_pending       = pending_q;
    assign cfg_done          = done_q;
    assign cfg_err           = err_q;
    assign sel_o             = sel_q;
    assign overload_en_o     = ovl_q;
    assign registered_mode_o = regm_q;

endmodule

// File: tb/tb_dice_router_cfg_loader.sv
// Directed self-checking bench for dice_router_cfg_loader.
module tb_dice_router_cfg_loader;

    logic        clk;
    logic        rst_n;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [31:0] cfg_data;
    logic        cfg_last;
    logic        commit_en;
    logic        cfg_err_clr;
    logic [47:0] sel_o;
    logic [11:0] overload_en_o;
    logic [11:0] registered_mode_o;
    logic        cfg_pending;
    logic        cfg_done;
    logic        cfg_err;

    int checks   = 0;
    int failures = 0;

    dice_router_cfg_loader dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .cfg_valid         (cfg_valid),
        .cfg_ready         (cfg_ready),
        .cfg_data          (cfg_data),
        .cfg_last          (cfg_last),
        .commit_en         (commit_en),
        .cfg_err_clr       (cfg_err_clr),
        .sel_o             (sel_o),
        .overload_en_o     (overload_en_o),
        .registered_mode_o (registered_mode_o),
        .cfg_pending       (cfg_pending),
        .cfg_done          (cfg_done),
        .cfg_err           (cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] d, input logic last);
        cfg_valid = 1'b1;
        cfg_data  = d;
        cfg_last  = last;
        step();
        cfg_valid = 1'b0;
        cfg_last  = 1'b0;
        cfg_data  = '0;
    endtask

    initial begin
        rst_n       = 1'b0;
        cfg_valid   = 1'b0;
        cfg_data    = '0;
        cfg_last    = 1'b0;
        commit_en   = 1'b0;
        cfg_err_clr = 1'b0;
        step();
        step();
        chk("rst_sel",     64'(sel_o), 64'hFFFF_FFFF_FFFF);
        chk("rst_ovl",     64'(overload_en_o), 64'h0);
        chk("rst_regm",    64'(registered_mode_o), 64'h0);
        chk("rst_ready",   64'(cfg_ready), 64'h1);
        chk("rst_pending", 64'(cfg_pending), 64'h0);
        chk("rst_done",    64'(cfg_done), 64'h0);
        chk("rst_err",     64'(cfg_err), 64'h0);
        rst_n = 1'b1;
        step();

        // Good frame with the minimum-latency commit.
        send(32'h7654_3210, 1'b0);
        chk("load_ready", 64'(cfg_ready), 64'h1);
        send(32'hF000_9898, 1'b0);
        send(32'h0000_0FFF, 1'b1);
        chk("g1_pending",  64'(cfg_pending), 64'h1);
        chk("g1_ready",    64'(cfg_ready), 64'h0);
        chk("g1_sel_old",  64'(sel_o), 64'hFFFF_FFFF_FFFF);
        commit_en = 1'b1;
        step();
        commit_en = 1'b0;
        chk("g1_sel",      64'(sel_o), 64'h9898_7654_3210);
        chk("g1_ovl",      64'(overload_en_o), 64'h000);
        chk("g1_regm",     64'(registered_mode_o), 64'hFFF);
        chk("g1_done",     64'(cfg_done), 64'h1);
        chk("g1_pend_off", 64'(cfg_pending), 64'h0);
        chk("g1_ready_on", 64'(cfg_ready), 64'h1);
        step();
        chk("g1_done_end", 64'(cfg_done), 64'h0);

        // Early cfg_last on word 1.
        send(32'h0000_0000, 1'b0);
        send(32'h0000_0000, 1'b1);
        chk("early_err",   64'(cfg_err), 64'h1);
        chk("early_ready", 64'(cfg_ready), 64'h1);
        chk("early_pend",  64'(cfg_pending), 64'h0);
        chk("early_sel",   64'(sel_o), 64'h9898_7654_3210);

        // Second good frame, held in PEND with cfg_valid high and no commit.
        send(32'h0123_4567, 1'b0);
        send(32'h0AAA_0089, 1'b0);
        send(32'hFFFF_FF5A, 1'b1);
        cfg_valid = 1'b1;
        cfg_data  = 32'h1111_1111;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("hold_ready", 64'(cfg_ready), 64'h0);
        end
        chk("hold_pend", 64'(cfg_pending), 64'h1);
        chk("hold_sel",  64'(sel_o), 64'h9898_7654_3210);
        chk("hold_done", 64'(cfg_done), 64'h0);
        chk("hold_err",  64'(cfg_err), 64'h1);
        cfg_valid = 1'b0;
        cfg_data  = '0;
        commit_en = 1'b1;
        step();
        commit_en = 1'b0;
        chk("g2_sel",  64'(sel_o), 64'h0089_0123_4567);
        chk("g2_ovl",  64'(overload_en_o), 64'hAAA);
        chk("g2_regm", 64'(registered_mode_o), 64'h5A0);
        chk("g2_done", 64'(cfg_done), 64'h1);
        cfg_err_clr = 1'b1;
        step();
        cfg_err_clr = 1'b0;
        chk("clr_err", 64'(cfg_err), 64'h0);

        // Commit request outside PEND is ignored.
        commit_en = 1'b1;
        step();
        commit_en = 1'b0;
        chk("idle_commit_done", 64'(cfg_done), 64'h0);

        // Out-of-range select in field 3.
        send(32'h0000_A000, 1'b0);
        send(32'h0000_0000, 1'b0);
        send(32'h0000_0000, 1'b1);
        chk("badsel_err",  64'(cfg_err), 64'h1);
        chk("badsel_pend", 64'(cfg_pending), 64'h0);
        chk("badsel_sel",  64'(sel_o), 64'h0089_0123_4567);

        // Missing cfg_last on the final word.
        cfg_err_clr = 1'b1;
        step();
        cfg_err_clr = 1'b0;
        chk("clr2_err", 64'(cfg_err), 64'h0);
        send(32'h0, 1'b0);
        send(32'h0, 1'b0);
        send(32'h0, 1'b0);
        chk("nolast_err",  64'(cfg_err), 64'h1);
        chk("nolast_pend", 64'(cfg_pending), 64'h0);

        // Clear and a new error in the same cycle: set wins.
        cfg_err_clr = 1'b1;
        send(32'h0, 1'b1);
        cfg_err_clr = 1'b0;
        chk("clr_vs_set_err", 64'(cfg_err), 64'h1);

        // Reset mid-frame restores defaults.
        send(32'h0000_0001, 1'b0);
        rst_n = 1'b0;
        #2;
        chk("mid_rst_sel",   64'(sel_o), 64'hFFFF_FFFF_FFFF);
        chk("mid_rst_ovl",   64'(overload_en_o), 64'h0);
        chk("mid_rst_regm",  64'(registered_mode_o), 64'h0);
        chk("mid_rst_ready", 64'(cfg_ready), 64'h1);
        chk("mid_rst_err",   64'(cfg_err), 64'h0);
        step();
        rst_n = 1'b1;
        step();

        // Frame after reset starts at word 0.
        send(32'h0000_0009, 1'b0);
        send(32'h0000_0000, 1'b0);
        send(32'h0000_0000, 1'b1);
        commit_en = 1'b1;
        step();
        commit_en = 1'b0;
        chk("post_rst_sel", 64'(sel_o), 64'h0000_0000_0009);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
